// File: rtl/cpu_core.sv
// -----------------------------------------------------------------------------
// cpu_core
//   10-bit accumulator CPU. It has a program ROM, a 16-word data RAM, one input
//   port and one registered output port. Each instruction takes two clocks:
//   FETCH (IR <= ROM[PC], PC++) and then EXECUTE. HALT stops the machine, and
//   only reset restarts it.
//
// Ports
//   clock    in   1       rising-edge clock
//   reset_n  in   1       asynchronous active-low reset
//   datain   in   DATA_W  input port, sampled by IN at its EXECUTE edge
//   dataout  out  DATA_W  output register, written only by OUT
//
// Instruction word: op=[15:12], k=[9:0], a=[3:0], t=[PC_W-1:0]
// -----------------------------------------------------------------------------
module cpu_core #(
    parameter int    DATA_W    = 10,
    parameter int    PC_W      = 8,
    parameter string PROG_FILE = ""
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] datain,
    output logic [DATA_W-1:0] dataout
);

    localparam int ROM_D = 1 << PC_W;
    localparam int RAM_D = 16;

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_LD   = 4'h2,
        OP_ST   = 4'h3,
        OP_ADD  = 4'h4,
        OP_SUB  = 4'h5,
        OP_AND  = 4'h6,
        OP_OR   = 4'h7,
        OP_IN   = 4'h8,
        OP_OUT  = 4'h9,
        OP_JMP  = 4'hA,
        OP_JZ   = 4'hB,
        OP_JC   = 4'hC,
        OP_RSVD = 4'hD,
        OP_RSVE = 4'hE,
        OP_HALT = 4'hF
    } op_t;

    // Decoded view of the instruction register
    typedef struct packed {
        op_t               op;
        logic [DATA_W-1:0] k;
        logic [3:0]        a;
        logic [PC_W-1:0]   t;
    } instr_t;

    // Result of the EXECUTE-phase datapath
    typedef struct packed {
        logic [DATA_W-1:0] acc;
        logic              c;
        logic              wr_acc;
        logic              wr_z;
    } alu_t;

    // ------------------------------------------------------------------
    // Program ROM. The default image is the doubling loop:
    //   0: IN  1: ST 0  2: ADD 0  3: OUT  4: JMP 0   (all other words are NOP)
    // ------------------------------------------------------------------
    logic [15:0] rom [ROM_D] = '{
        0: 16'h8000,
        1: 16'h3000,
        2: 16'h4000,
        3: 16'h9000,
        4: 16'hA000,
        default: 16'h0000
    };

    // ------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------
    state_t            state;
    logic [PC_W-1:0]   pc;
    logic [15:0]       ir;
    logic [DATA_W-1:0] acc;
    logic              z;
    logic              c;
    logic [DATA_W-1:0] ram [RAM_D];

    instr_t            d;
    alu_t              alu;
    logic [DATA_W-1:0] ram_rd;
    logic              jump;

    // Bits [11:10] do not belong to any operand field
    logic unused_ir;
    assign unused_ir = ^ir[11:10];

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    always_comb begin
        d.op = op_t'(ir[15:12]);
        d.k  = DATA_W'(ir[9:0]);
        d.a  = ir[3:0];
        d.t  = ir[PC_W-1:0];
    end

    // The RAM is read combinationally. ST only writes, so a read and a write
    // never target the RAM in the same cycle.
    assign ram_rd = ram[d.a];

    // ------------------------------------------------------------------
    // Datapath. C defaults to its old value, so only ADD/SUB change it.
    // ------------------------------------------------------------------
    always_comb begin
        alu.acc    = acc;
        alu.c      = c;
        alu.wr_acc = 1'b0;
        alu.wr_z   = 1'b0;
        unique case (d.op)
            OP_LDI: begin
                alu.acc    = d.k;
                alu.wr_acc = 1'b1;
                alu.wr_z   = 1'b1;
            end
            OP_LD: begin
                alu.acc    = ram_rd;
                alu.wr_acc = 1'b1;
                alu.wr_z   = 1'b1;
            end
            OP_ADD: begin
                {alu.c, alu.acc} = {1'b0, acc} + {1'b0, ram_rd};
                alu.wr_acc       = 1'b1;
                alu.wr_z         = 1'b1;
            end
            OP_SUB: begin
                alu.acc    = acc - ram_rd;
                alu.c      = (acc < ram_rd);
                alu.wr_acc = 1'b1;
                alu.wr_z   = 1'b1;
            end
            OP_AND: begin
                alu.acc    = acc & ram_rd;
                alu.wr_acc = 1'b1;
                alu.wr_z   = 1'b1;
            end
            OP_OR: begin
                alu.acc    = acc | ram_rd;
                alu.wr_acc = 1'b1;
                alu.wr_z   = 1'b1;
            end
            OP_IN: begin
                alu.acc    = datain;
                alu.wr_acc = 1'b1;
                alu.wr_z   = 1'b1;
            end
            default: ;
        endcase
    end

    // Branch decision. Z and C are read here before this EXECUTE updates them.
    always_comb begin
        unique case (d.op)
            OP_JMP:  jump = 1'b1;
            OP_JZ:   jump = z;
            OP_JC:   jump = c;
            default: jump = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer and state update
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_FETCH;
            pc      <= '0;
            ir      <= '0;
            acc     <= '0;
            z       <= 1'b0;
            c       <= 1'b0;
            dataout <= '0;
            for (int i = 0; i < RAM_D; i++) begin
                ram[i] <= '0;
            end
        end else begin
            unique case (state)
                S_FETCH: begin
                    ir    <= rom[pc];
                    pc    <= pc + PC_W'(1);  // wraps at ROM depth
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    state <= (d.op == OP_HALT) ? S_HALT : S_FETCH;
                    if (alu.wr_acc) acc <= alu.acc;
                    if (alu.wr_z)   z   <= (alu.acc == '0);
                    c <= alu.c;
                    if (d.op == OP_ST)  ram[d.a] <= acc;
                    if (d.op == OP_OUT) dataout  <= acc;
                    // A jump overrides the increment made during FETCH
                    if (jump) pc <= d.t;
                end
                S_HALT: ;  // everything holds until reset
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// -----------------------------------------------------------------------------
// tb_cpu_core
//   Directed bench for cpu_core. It runs the built-in doubling program and then
//   several small programs written into the ROM while reset is held. It checks
//   dataout and the architectural state against values worked out by hand.
// -----------------------------------------------------------------------------
module tb_cpu_core;

    logic       clock;
    logic       reset_n;
    logic [9:0] datain;
    logic [9:0] dataout;

    int checks = 0;
    int errors = 0;

    logic [15:0] prog [$];

    cpu_core dut (
        .clock   (clock),
        .reset_n (reset_n),
        .datain  (datain),
        .dataout (dataout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then sample 1 time unit after the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Hold reset, clear the ROM, and write the program from word 0 upward
    task automatic load(input logic [15:0] p [$]);
        @(negedge clock);
        reset_n = 1'b0;
        for (int i = 0; i < 256; i++) dut.rom[i] = 16'h0000;
        for (int i = 0; i < p.size(); i++) dut.rom[i] = p[i];
        @(negedge clock);
    endtask

    // Release reset between edges. Edge counting starts from the next edge.
    task automatic go();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        datain  = 10'd10;
        tick(2);
        chk("reset_dataout", dataout, 0);
        chk("reset_pc", dut.pc, 0);
        chk("reset_acc", dut.acc, 0);

        // ---- default program: first OUT lands on edge 8 ----
        go();
        tick(7);
        chk("first_out_not_before_8", dataout, 0);
        tick(1);
        chk("first_out_edge8", dataout, 20);
        tick(10);                       // edge 18
        chk("refresh_20", dataout, 20);
        datain = 10'd13;                // sampled by IN at edge 22
        tick(9);                        // edge 27
        chk("hold_between_out", dataout, 20);
        tick(1);                        // edge 28
        chk("step_13", dataout, 26);
        datain = 10'd16;
        tick(10);                       // edge 38
        chk("step_16", dataout, 32);

        // ---- asynchronous reset in the middle of EXECUTE ----
        tick(1);                        // edge 39, state EXECUTE
        reset_n = 1'b0;
        #1;
        chk("async_rst_dataout", dataout, 0);
        chk("async_rst_pc", dut.pc, 0);

        // ---- wrap: 2*600 mod 1024 = 176 ----
        datain = 10'd600;
        tick(2);
        go();
        tick(8);
        chk("wrap_176", dataout, 176);

        // ---- ADD carry out and JC taken ----
        // LDI 600; ST 0; ADD 0; JC 6; LDI 1; HALT; OUT; HALT
        prog = '{16'h1258, 16'h3000, 16'h4000, 16'hC006, 16'h1001, 16'hF000, 16'h9000, 16'hF000};
        load(prog);
        go();
        tick(30);
        chk("jc_taken_out", dataout, 176);
        chk("jc_carry", dut.c, 1);
        chk("jc_halt_pc", dut.pc, 8);

        // ---- Z branch and HALT ----
        // LDI 5; ST 1; LDI 5; SUB 1; JZ 7; OUT; HALT; LDI 1023; OUT; HALT
        prog = '{16'h1005, 16'h3001, 16'h1005, 16'h5001, 16'hB007, 16'h9000, 16'hF000,
                 16'h13FF, 16'h9000, 16'hF000};
        load(prog);
        go();
        tick(30);
        chk("jz_taken_out", dataout, 1023);
        chk("jz_final_z", dut.z, 0);
        tick(100);
        chk("halt_stable_out", dataout, 1023);
        chk("halt_stable_pc", dut.pc, 10);

        // ---- SUB borrow, then LD ----
        // LDI 3; ST 0; LDI 1; SUB 0; OUT; LD 0; OUT; HALT
        prog = '{16'h1003, 16'h3000, 16'h1001, 16'h5000, 16'h9000, 16'h2000, 16'h9000, 16'hF000};
        load(prog);
        go();
        tick(10);                       // OUT at edge 10
        chk("sub_borrow_out", dataout, 1022);
        chk("sub_borrow_c", dut.c, 1);
        chk("sub_borrow_z", dut.z, 0);
        tick(4);                        // OUT at edge 14
        chk("ld_out", dataout, 3);
        chk("ld_keeps_c", dut.c, 1);

        // ---- AND / OR, with opcode D as a NOP ----
        // LDI 2AA; ST 2; LDI 0F0; AND 2; OUT; OR 2; D; OUT; HALT
        prog = '{16'h12AA, 16'h3002, 16'h10F0, 16'h6002, 16'h9000, 16'h7002, 16'hD000,
                 16'h9000, 16'hF000};
        load(prog);
        go();
        tick(10);
        chk("and_out", dataout, 10'h0A0);
        tick(5);                        // edge 15
        chk("and_hold", dataout, 10'h0A0);
        tick(1);                        // edge 16
        chk("or_out", dataout, 10'h2AA);
        chk("logic_c_unchanged", dut.c, 0);

        // ---- PC wrap: word 0 OUT, word 1 IN, the rest NOP ----
        prog = '{16'h9000, 16'h8000};
        datain = 10'd7;
        load(prog);
        go();
        tick(5);                        // IN sampled 7 at edge 4
        chk("wrap_first_out", dataout, 0);
        datain = 10'd9;
        tick(508);                      // edge 513
        chk("wrap_before_514", dataout, 0);
        tick(1);                        // edge 514
        chk("wrap_out_514", dataout, 7);
        tick(511);                      // edge 1025
        chk("wrap_before_1026", dataout, 7);
        tick(1);                        // edge 1026
        chk("wrap_out_1026", dataout, 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
